// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_e;

endpackage : sub_pkg

// File: rtl/full_subtractor.sv
// Combinational one-bit full subtractor: d = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~a & bin) | (b & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor, Diff = A - B - Bin over WIDTH cycles with start/done handshake.
// Optional signed-overflow output `ovf` is built when OVERFLOW_EN is defined.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
`ifdef OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             Bout
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  sub_state_e       state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic [CW-1:0]    cnt_q;
  logic             br_q;
  logic             busy_q;
  logic             done_q;
  logic             bout_q;
  logic             bit_d_c;
  logic             bit_bout_c;
`ifdef OVERFLOW_EN
  logic             a_msb_q;
  logic             b_msb_q;
  logic             ovf_q;
`endif

  full_subtractor u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (bit_d_c),
    .bout (bit_bout_c)
  );

  // Control FSM and datapath; diff_q doubles as the visible result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
`ifdef OVERFLOW_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            br_q    <= Bin;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef OVERFLOW_EN
            a_msb_q <= A[WIDTH-1];
            b_msb_q <= B[WIDTH-1];
`endif
          end
        end
        RUN: begin
          if (cnt_q != CW'(WIDTH)) begin
            a_q    <= a_q >> 1;
            b_q    <= b_q >> 1;
            diff_q <= {bit_d_c, diff_q[WIDTH-1:1]};
            br_q   <= bit_bout_c;
            cnt_q  <= cnt_q + CW'(1);
          end else begin
            // All bits processed: publish borrow and pulse done on the same edge.
            bout_q  <= br_q;
            done_q  <= 1'b1;
            state_q <= DONE;
`ifdef OVERFLOW_EN
            ovf_q   <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ diff_q[WIDTH-1]);
`endif
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign Diff = diff_q;
  assign Bout = bout_q;
`ifdef OVERFLOW_EN
  assign ovf  = ovf_q;
`endif

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8); checks ovf when OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         ovf_s;

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .busy  (busy),
    .done  (done),
    .Diff  (Diff),
`ifdef OVERFLOW_EN
    .ovf   (ovf_s),
`endif
    .Bout  (Bout)
  );

`ifndef OVERFLOW_EN
  assign ovf_s = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Launch one operation and follow it until busy drops; returns latency and result seen at done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        output int lat, output int bcnt, output int dcnt,
                        output logic [W-1:0] r_diff, output logic r_bout, output logic r_ovf);
    bit finished;
    lat = 0; bcnt = 1; dcnt = 0; r_diff = '0; r_bout = 1'b0; r_ovf = 1'b0;
    finished = 1'b0;
    A = a; B = b; Bin = bin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = i; r_diff = Diff; r_bout = Bout; r_ovf = ovf_s;
        end
      end
      if (!busy) begin
        finished = 1'b1;
        break;
      end
    end
    if (!finished) chk("op_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bout;
  } vec_t;

  vec_t vecs[4];
  int lat, bcnt, dcnt;
  logic [W-1:0] r_diff;
  logic r_bout, r_ovf;
  int done_edges[$];
  logic [W-1:0] done_diffs[$];

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    vecs[0] = '{8'd100, 8'd37, 1'b0, 8'd63,  1'b0};
    vecs[1] = '{8'd5,   8'd9,  1'b0, 8'd252, 1'b1};
    vecs[2] = '{8'd0,   8'd0,  1'b1, 8'd255, 1'b1};
    vecs[3] = '{8'd255, 8'd255,1'b0, 8'd0,   1'b0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(Diff), 32'd0);
    chk("rst_bout", 32'(Bout), 32'd0);
    rst = 1'b0;

    foreach (vecs[k]) begin
      run_op(vecs[k].a, vecs[k].b, vecs[k].bin, lat, bcnt, dcnt, r_diff, r_bout, r_ovf);
      chk("latency", 32'(lat), 32'd9);
      chk("busy_cycles", 32'(bcnt), 32'd10);
      chk("done_pulses", 32'(dcnt), 32'd1);
      chk("diff", 32'(r_diff), 32'(vecs[k].diff));
      chk("bout", 32'(r_bout), 32'(vecs[k].bout));
      repeat (2) @(posedge clk);
      #1;
      chk("diff_hold", 32'(Diff), 32'(vecs[k].diff));
      chk("bout_hold", 32'(Bout), 32'(vecs[k].bout));
    end

    // start held high across three back-to-back operations, operands churned every cycle
    A = 8'd20; B = 8'd5; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      if (done) begin
        done_edges.push_back(e);
        done_diffs.push_back(Diff);
      end
      A = W'(3 * e + 40);
      B = W'(e);
    end
    start = 1'b0;
    chk("held_done_count", 32'(done_edges.size()), 32'd3);
    if (done_edges.size() == 3) begin
      chk("held_done0_edge", 32'(done_edges[0]), 32'd9);
      chk("held_done1_edge", 32'(done_edges[1]), 32'd20);
      chk("held_done2_edge", 32'(done_edges[2]), 32'd31);
      chk("held_diff0", 32'(done_diffs[0]), 32'd15);
      chk("held_diff1", 32'(done_diffs[1]), 32'd60);
      chk("held_diff2", 32'(done_diffs[2]), 32'd82);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("held_idle_after", 32'(busy), 32'd0);

    // asynchronous reset in the middle of RUN
    A = 8'd100; B = 8'd37; Bin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_diff", 32'(Diff), 32'd0);
    chk("arst_bout", 32'(Bout), 32'd0);
    #2;
    rst = 1'b0;
    run_op(8'd10, 8'd3, 1'b0, lat, bcnt, dcnt, r_diff, r_bout, r_ovf);
    chk("post_rst_latency", 32'(lat), 32'd9);
    chk("post_rst_diff", 32'(r_diff), 32'd7);
    chk("post_rst_bout", 32'(r_bout), 32'd0);

`ifdef OVERFLOW_EN
    run_op(8'h80, 8'h01, 1'b0, lat, bcnt, dcnt, r_diff, r_bout, r_ovf);
    chk("ovf_diff", 32'(r_diff), 32'h7f);
    chk("ovf_set", 32'(r_ovf), 32'd1);
    run_op(8'h10, 8'h01, 1'b0, lat, bcnt, dcnt, r_diff, r_bout, r_ovf);
    chk("ovf_diff2", 32'(r_diff), 32'h0f);
    chk("ovf_clear", 32'(r_ovf), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_serial_subtractor
